// File: rtl/mdu_unit.sv
// HI/LO multiply/divide unit with fixed-latency commit of MULT/MULTU/DIV/DIVU and immediate MTHI/MTLO.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (7-10).
module mdu_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [3:0]  op_i,
   input  logic [31:0] rs_data_i,
   input  logic [31:0] rt_data_i,
   input  logic        read_hi_i,
   output logic        busy_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic [31:0] rd_data_o
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      hiPend_q, hiPend_d, loPend_q, loPend_d;
   logic             pendValid_q, pendValid_d;

   logic [63:0] prodS, prodU;
   logic        aNeg, bNeg;
   logic [31:0] aAbs, bAbs, divisorU, divisorS;
   logic [31:0] quotU, remU, qMag, rMag, quotS, remS;

   assign prodS = $signed({{32{rs_data_i[31]}}, rs_data_i}) * $signed({{32{rt_data_i[31]}}, rt_data_i});
   assign prodU = {32'd0, rs_data_i} * {32'd0, rt_data_i};

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
   assign aNeg     = rs_data_i[31];
   assign bNeg     = rt_data_i[31];
   assign aAbs     = aNeg ? (32'd0 - rs_data_i) : rs_data_i;
   assign bAbs     = bNeg ? (32'd0 - rt_data_i) : rt_data_i;
   assign divisorU = (rt_data_i == 32'd0) ? 32'd1 : rt_data_i;
   assign divisorS = (bAbs == 32'd0) ? 32'd1 : bAbs;
   assign quotU    = rs_data_i / divisorU;
   assign remU     = rs_data_i % divisorU;
   assign qMag     = aAbs / divisorS;
   assign rMag     = aAbs % divisorS;
   assign quotS    = (aNeg ^ bNeg) ? (32'd0 - qMag) : qMag;
   assign remS     = aNeg ? (32'd0 - rMag) : rMag;

`ifdef MDU_MADD_EN
   logic [63:0] acc;
   assign acc = {hi_q, lo_q};
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      hiPend_d    = hiPend_q;
      loPend_d    = loPend_q;
      pendValid_d = pendValid_q;

      if (state_q == ST_IDLE) begin
         if (start_i) begin
            case (op_i)
               OP_MULT, OP_MULTU: begin
                  {hiPend_d, loPend_d} = (op_i == OP_MULT) ? prodS : prodU;
                  pendValid_d = 1'b1;
                  cnt_d       = CNT_W'(MULT_CYCLES);
                  state_d     = ST_BUSY;
               end
               OP_DIV, OP_DIVU: begin
                  hiPend_d    = (op_i == OP_DIV) ? remS : remU;
                  loPend_d    = (op_i == OP_DIV) ? quotS : quotU;
                  pendValid_d = (rt_data_i != 32'd0);
                  cnt_d       = CNT_W'(DIV_CYCLES);
                  state_d     = ST_BUSY;
               end
`ifdef MDU_MADD_EN
               OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                  case (op_i)
                     OP_MADD:  {hiPend_d, loPend_d} = acc + prodS;
                     OP_MADDU: {hiPend_d, loPend_d} = acc + prodU;
                     OP_MSUB:  {hiPend_d, loPend_d} = acc - prodS;
                     default:  {hiPend_d, loPend_d} = acc - prodU;
                  endcase
                  pendValid_d = 1'b1;
                  cnt_d       = CNT_W'(MULT_CYCLES);
                  state_d     = ST_BUSY;
               end
`endif
               OP_MTHI: hi_d = rs_data_i;
               OP_MTLO: lo_d = rs_data_i;
               default: ;
            endcase
         end
      end else begin
         // Any start while busy is dropped; only the countdown matters here.
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            state_d     = ST_IDLE;
            pendValid_d = 1'b0;
            if (pendValid_q) begin
               hi_d = hiPend_q;
               lo_d = loPend_q;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         hiPend_q    <= 32'd0;
         loPend_q    <= 32'd0;
         pendValid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         hiPend_q    <= hiPend_d;
         loPend_q    <= loPend_d;
         pendValid_q <= pendValid_d;
      end
   end

   assign busy_o    = (state_q == ST_BUSY);
   assign hi_o      = hi_q;
   assign lo_o      = lo_q;
   assign rd_data_o = read_hi_i ? hi_q : lo_q;

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Iterative-latency multiply/divide unit for the pipelined MIPS core: executes MULT/MULTU/DIV/DIVU and MTHI/MTLO from the E stage and owns the HI/LO registers read by MFHI/MFLO. Sits beside the ALU in E, downstream of the ID/EX pipeline register; its `busy` feeds the hazard unit, which stalls any multiply/divide-class instruction in D while `start | busy` is high.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for multiply-class ops.
- `DIV_CYCLES`, default 10: busy cycles for divide-class ops.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low; sampled on rising `clk`.
- `start`  in  1: op in E is a multiply/divide-class op; single-cycle qualifier for `op`.
- `op`  in  4: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11–15 reserved (treated as NONE).
- `rs_data`  in  32: operand A (dividend / multiplicand / MTHI-MTLO source).
- `rt_data`  in  32: operand B (divisor / multiplier).
- `read_hi`  in  1: 1 selects HI, 0 selects LO on `rd_data`.
- `busy`  out  1: operation in flight.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.
- `rd_data`  out  32: `read_hi ? hi : lo`, combinational from registers.

## Operation
- Idle state (`busy`=0): on edge with `start`=1:
  - MULT/MULTU/DIV/DIVU (and MADD* / MSUB* when enabled): latch result into internal `hi_pend`/`lo_pend`, load counter with MULT_CYCLES or DIV_CYCLES, `busy`←1. HI/LO unchanged.
  - MTHI/MTLO: write `rs_data` into HI/LO at that edge; `busy` stays 0.
  - NONE/reserved: no effect.
- Busy state: counter decrements each edge; on edge where counter goes 1→0, HI←`hi_pend`, LO←`lo_pend`, `busy`←0.
- `start` while `busy`=1: ignored entirely (hazard unit guarantees this never happens; bench checks it is harmless).
- Arithmetic: MULT signed 32×32→64, MULTU unsigned; {HI,LO}=product. DIV: LO=signed quotient truncated toward zero, HI=remainder with dividend's sign; DIVU unsigned. 0x80000000 / −1 signed: LO=0x80000000, HI=0.
- Divide by zero (`rt_data`=0): full DIV_CYCLES latency, HI/LO left unchanged at completion.
- `rd_data` reflects registers only; no bypass of `hi_pend`/`lo_pend`.

## Timing
- Reset (`reset`=0 at edge): HI=0, LO=0, counter=0, `busy`=0, pending cleared; overrides `start`, aborts in-flight op with no HI/LO write.
- Start at edge T: `busy`=1 after T through edge T+N−1; HI/LO updated and `busy`=0 after edge T+N (N=MULT_CYCLES or DIV_CYCLES). `busy` high exactly N cycles.
- MTHI/MTLO: HI/LO visible the cycle after the `start` edge.
- Back-to-back: new op accepted at the same edge `busy` falls only if `busy`=0 when sampled, i.e. earliest next start is edge T+N+1.
- MFHI following a MULT: hazard unit stalls while `start|busy`; first non-stalled read sees new value.

## Configuration
- `MDU_MADD_EN` defined: ops 7–10 valid; MADD/MADDU: {HI,LO}←{HI,LO}+product (signed/unsigned), MSUB/MSUBU: {HI,LO}←{HI,LO}−product, 64-bit wrap; HI/LO sampled at start edge; latency MULT_CYCLES.
- Undefined: ops 7–10 treated as NONE (no busy, no write).

## Test plan
- Reset: hold `reset`=0 two cycles after random ops -> HI=LO=0, `busy`=0; assert mid-DIV at cycle 4 -> `busy`=0 next cycle, HI/LO stay 0.
- MULT rs=0xFFFFFFFF rt=2 -> `busy` high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001 LO=0xFFFFFFFE.
- DIV rs=−7 (0xFFFFFFF9) rt=2 -> `busy` 10 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU 7/0 -> 10 busy cycles, HI/LO unchanged.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> HI/LO updated each next cycle, `busy`=0, `rd_data` follows `read_hi`.
- MULT started, then `start`=1 with DIVU at busy cycle 2 -> DIVU ignored, MULT result committed at cycle 5.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, MADDU 1×1 -> HI=1 LO=0; without macro same op -> no busy, HI/LO unchanged.
